// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - command codes and scheduler state encoding for the LCD command scheduler
// Purpose: shared constants for lcd_cmd_sched and lcd_cmd_fifo.
// Contents: CMD_* command codes (3 bits), sched_state_t FSM encoding.
package lcd_pkg;

  localparam logic [2:0] CMD_WRITE       = 3'd0;
  localparam logic [2:0] CMD_SHIFT_UP    = 3'd1;
  localparam logic [2:0] CMD_SHIFT_DOWN  = 3'd2;
  localparam logic [2:0] CMD_SHIFT_LEFT  = 3'd3;
  localparam logic [2:0] CMD_SHIFT_RIGHT = 3'd4;
  localparam logic [2:0] CMD_AVERAGE     = 3'd5;
  localparam logic [2:0] CMD_MIRROR_X    = 3'd6;
  localparam logic [2:0] CMD_MIRROR_Y    = 3'd7;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    GAP       = 3'd2,
    WAIT_DONE = 3'd3,
    FINISH    = 3'd4
  } sched_state_t;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// rtl/lcd_cmd_fifo.sv - synchronous first-word-fall-through command FIFO
// Purpose: buffers host commands; head is valid whenever o_empty is low.
// Ports: clk, reset (async, active-high), i_push/i_data write side,
//        i_pop read side, o_head current head entry, o_level occupancy,
//        o_full / o_empty status.
import lcd_pkg::*;

module lcd_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_head,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Storage carries no reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  // Power-of-2 depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/lcd_cmd_sched.sv
// rtl/lcd_cmd_sched.sv - host-to-LCD-controller command scheduler with done watchdog
// Purpose: queue host commands, issue them one strobe at a time while the
//          controller is idle, and track the terminal Write to completion.
// Ports: clk, reset (async, active-high)
//        i_host_cmd/i_host_valid/o_host_ready  host command handshake
//        o_lcd_cmd/o_lcd_cmd_valid             single-cycle issue strobe
//        i_lcd_busy/i_lcd_done                 controller status
//        o_fifo_level, o_issue_cnt             occupancy and issue count
//        o_sched_done, o_err_timeout           sticky completion / watchdog flags
import lcd_pkg::*;

module lcd_cmd_sched #(
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 256,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [2:0]                    i_host_cmd,
  input  logic                          i_host_valid,
  output logic                          o_host_ready,
  output logic [2:0]                    o_lcd_cmd,
  output logic                          o_lcd_cmd_valid,
  input  logic                          i_lcd_busy,
  input  logic                          i_lcd_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic [CNT_W-1:0]              o_issue_cnt,
  output logic                          o_sched_done,
  output logic                          o_err_timeout
);

  localparam int WT_W = $clog2(TIMEOUT + 1);
  localparam logic [3:0]      GAP_LAST  = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [WT_W-1:0] WAIT_LAST = WT_W'(TIMEOUT - 1);

  sched_state_t     r_state;
  sched_state_t     w_next;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [2:0]       w_head;
  logic             r_sealed;
  logic [3:0]       r_gap_cnt;
  logic [WT_W-1:0]  r_wait_cnt;
  logic [2:0]       r_lcd_cmd;
  logic             r_lcd_cmd_valid;
  logic [CNT_W-1:0] r_issue_cnt;
  logic             r_err_timeout;

  // Once a Write is queued nothing else may follow it.
  assign o_host_ready = !w_full && !r_sealed;
  assign w_push       = i_host_valid && o_host_ready;

  lcd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (3)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (i_host_cmd),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_level (o_fifo_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      IDLE: begin
        // Busy is only looked at here; a later rise cannot cancel an issue.
        if (!i_lcd_busy && !w_empty) w_next = ISSUE;
      end
      ISSUE: begin
        w_pop = 1'b1;
        if (w_head == CMD_WRITE)  w_next = WAIT_DONE;
        else if (GAP_CYCLES == 0) w_next = IDLE;
        else                      w_next = GAP;
      end
      GAP: begin
        if (r_gap_cnt == GAP_LAST) w_next = IDLE;
      end
      WAIT_DONE: begin
        if (i_lcd_done) w_next = FINISH;
      end
      FINISH:  w_next = FINISH;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sealed        <= 1'b0;
      r_gap_cnt       <= '0;
      r_wait_cnt      <= '0;
      r_lcd_cmd       <= '0;
      r_lcd_cmd_valid <= 1'b0;
      r_issue_cnt     <= '0;
      r_err_timeout   <= 1'b0;
    end else begin
      if (w_push && (i_host_cmd == CMD_WRITE)) r_sealed <= 1'b1;

      // Strobe and issue count move together on the cycle after ISSUE.
      r_lcd_cmd_valid <= (r_state == ISSUE);
      if (r_state == ISSUE) begin
        r_lcd_cmd <= w_head;
        if (r_issue_cnt != '1) r_issue_cnt <= r_issue_cnt + 1'b1;
      end

      if (r_state == ISSUE)    r_gap_cnt <= '0;
      else if (r_state == GAP) r_gap_cnt <= r_gap_cnt + 1'b1;

      // Wait counter holds at its last value; err stays sticky afterwards.
      if (r_state == ISSUE) begin
        r_wait_cnt <= '0;
      end else if (r_state == WAIT_DONE) begin
        if (r_wait_cnt != WAIT_LAST) r_wait_cnt <= r_wait_cnt + 1'b1;
        if (r_wait_cnt == WAIT_LAST && !i_lcd_done) r_err_timeout <= 1'b1;
      end
    end
  end

  assign o_lcd_cmd       = r_lcd_cmd;
  assign o_lcd_cmd_valid = r_lcd_cmd_valid;
  assign o_issue_cnt     = r_issue_cnt;
  assign o_sched_done    = (r_state == FINISH);
  assign o_err_timeout   = r_err_timeout;

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// tb/tb_lcd_cmd_sched.sv - directed self-checking bench for lcd_cmd_sched
module tb_lcd_cmd_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  host_cmd;
  logic        host_valid;
  logic        host_ready;
  logic [2:0]  lcd_cmd;
  logic        lcd_cmd_valid;
  logic        lcd_busy;
  logic        lcd_done;
  logic [3:0]  fifo_level;
  logic [15:0] issue_cnt;
  logic        sched_done;
  logic        err_timeout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lcd_cmd_sched #(
    .FIFO_DEPTH (8),
    .GAP_CYCLES (1),
    .TIMEOUT    (256),
    .CNT_W      (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_host_cmd      (host_cmd),
    .i_host_valid    (host_valid),
    .o_host_ready    (host_ready),
    .o_lcd_cmd       (lcd_cmd),
    .o_lcd_cmd_valid (lcd_cmd_valid),
    .i_lcd_busy      (lcd_busy),
    .i_lcd_done      (lcd_done),
    .o_fifo_level    (fifo_level),
    .o_issue_cnt     (issue_cnt),
    .o_sched_done    (sched_done),
    .o_err_timeout   (err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_strobe(input int budget, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      step();
      n++;
      if (lcd_cmd_valid) ok = 1'b1;
    end
  endtask

  task automatic no_strobe(input int cycles, input string tag);
    bit seen;
    seen = 1'b0;
    repeat (cycles) begin
      step();
      if (lcd_cmd_valid) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  task automatic push(input logic [2:0] c);
    host_cmd   = c;
    host_valid = 1'b1;
    step();
    host_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin : main
    int n;
    bit ok;
    bit flag;
    logic [2:0] t2_cmds [9];
    t2_cmds = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2};

    reset = 1'b1; host_cmd = '0; host_valid = 1'b0; lcd_busy = 1'b0; lcd_done = 1'b0;
    step();
    step();
    chk("rst_ready", 32'(host_ready), 32'd1);
    chk("rst_valid", 32'(lcd_cmd_valid), 32'd0);
    chk("rst_cmd", 32'(lcd_cmd), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_cnt", 32'(issue_cnt), 32'd0);
    chk("rst_done", 32'(sched_done), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    reset = 1'b0;
    step();

    // 1: busy holds queued commands; gap spacing between strobes
    lcd_busy = 1'b1;
    push(3'd1);
    push(3'd5);
    no_strobe(68, "t1_busy_hold");
    chk("t1_level", 32'(fifo_level), 32'd2);
    lcd_busy = 1'b0;
    wait_strobe(20, n, ok);
    chk("t1_s1_ok", 32'(ok), 32'd1);
    chk("t1_s1_cmd", 32'(lcd_cmd), 32'd1);
    wait_strobe(20, n, ok);
    chk("t1_s2_ok", 32'(ok), 32'd1);
    chk("t1_spacing", 32'(n), 32'd3);
    chk("t1_s2_cmd", 32'(lcd_cmd), 32'd5);
    chk("t1_cnt", 32'(issue_cnt), 32'd2);
    step();
    chk("t1_cmd_hold", 32'(lcd_cmd), 32'd5);
    chk("t1_level0", 32'(fifo_level), 32'd0);

    // 2: fill to full, ninth offer refused, drain in order
    lcd_busy = 1'b1;
    for (int i = 0; i < 9; i++) push(t2_cmds[i]);
    chk("t2_ready_full", 32'(host_ready), 32'd0);
    chk("t2_level_full", 32'(fifo_level), 32'd8);
    lcd_busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_strobe(20, n, ok);
      chk($sformatf("t2_s%0d_ok", i), 32'(ok), 32'd1);
      chk($sformatf("t2_s%0d_cmd", i), 32'(lcd_cmd), 32'(t2_cmds[i]));
    end
    chk("t2_cnt", 32'(issue_cnt), 32'd10);
    no_strobe(20, "t2_no_ninth");
    chk("t2_level0", 32'(fifo_level), 32'd0);
    chk("t2_ready_again", 32'(host_ready), 32'd1);

    // 3: Write seals the input
    lcd_busy = 1'b1;
    host_cmd = 3'd0; host_valid = 1'b1;
    #1 chk("t3_ready_pre", 32'(host_ready), 32'd1);
    step();
    chk("t3_ready_sealed", 32'(host_ready), 32'd0);
    host_cmd = 3'd6;
    flag = 1'b0;
    repeat (5) begin
      step();
      if (host_ready) flag = 1'b1;
    end
    host_valid = 1'b0;
    chk("t3_mirrorx_refused", 32'(flag), 32'd0);
    chk("t3_level", 32'(fifo_level), 32'd1);
    lcd_busy = 1'b0;
    wait_strobe(20, n, ok);
    chk("t3_w_ok", 32'(ok), 32'd1);
    chk("t3_w_cmd", 32'(lcd_cmd), 32'd0);
    chk("t3_cnt", 32'(issue_cnt), 32'd11);

    // 4: done 65 cycles after Write strobe
    no_strobe(64, "t4_wait_quiet");
    lcd_done = 1'b1;
    chk("t4_done_pre", 32'(sched_done), 32'd0);
    step();
    lcd_done = 1'b0;
    chk("t4_done", 32'(sched_done), 32'd1);
    no_strobe(30, "t4_after_done");
    chk("t4_done_sticky", 32'(sched_done), 32'd1);
    chk("t4_err", 32'(err_timeout), 32'd0);
    chk("t4_cnt", 32'(issue_cnt), 32'd11);

    // 5: watchdog, lcd_done in IDLE ignored
    do_reset();
    lcd_done = 1'b1;
    step();
    lcd_done = 1'b0;
    step();
    chk("t5_done_idle_ignored", 32'(sched_done), 32'd0);
    push(3'd0);
    wait_strobe(20, n, ok);
    chk("t5_w_ok", 32'(ok), 32'd1);
    chk("t5_w_cmd", 32'(lcd_cmd), 32'd0);
    repeat (255) step();
    chk("t5_err_before", 32'(err_timeout), 32'd0);
    step();
    chk("t5_err_at", 32'(err_timeout), 32'd1);
    chk("t5_not_done", 32'(sched_done), 32'd0);
    lcd_done = 1'b1;
    step();
    lcd_done = 1'b0;
    chk("t5_late_done", 32'(sched_done), 32'd1);
    chk("t5_err_sticky", 32'(err_timeout), 32'd1);

    // 6: asynchronous reset during GAP with a strobe in flight
    do_reset();
    lcd_busy = 1'b1;
    push(3'd3);
    push(3'd4);
    push(3'd5);
    push(3'd6);
    lcd_busy = 1'b0;
    wait_strobe(20, n, ok);
    chk("t6_s_ok", 32'(ok), 32'd1);
    chk("t6_s_cmd", 32'(lcd_cmd), 32'd3);
    chk("t6_level3", 32'(fifo_level), 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(lcd_cmd_valid), 32'd0);
    chk("t6_rst_level", 32'(fifo_level), 32'd0);
    chk("t6_rst_cnt", 32'(issue_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    no_strobe(20, "t6_no_survivor");
    push(3'd7);
    wait_strobe(20, n, ok);
    chk("t6_new_ok", 32'(ok), 32'd1);
    chk("t6_new_cmd", 32'(lcd_cmd), 32'd7);
    chk("t6_new_cnt", 32'(issue_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_sched.md
Name: lcd_cmd_sched

Overview:
- Command scheduler in front of the LCD image controller.
- Accepts image commands from a host over a valid/ready interface and buffers them in a small FIFO.
- Issues each command to the controller as a single-cycle cmd_valid pulse, only while the controller reports not-busy.
- Tracks the terminal Write command through to controller done, with issue counting and a done-timeout watchdog.

Parameters:
- FIFO_DEPTH, 8, command FIFO entries; power of 2, minimum 2.
- GAP_CYCLES, 1, idle cycles forced between consecutive issues; range 0..15.
- TIMEOUT, 256, max cycles in WAIT_DONE before err_timeout sets.
- CNT_W, 16, width of issue_cnt.

Ports:
- clk  in  1  clock; all flops rising-edge.
- reset  in  1  asynchronous, active-high reset.
- host_cmd  in  3  command code: 0 Write, 1 ShiftUp, 2 ShiftDown, 3 ShiftLeft, 4 ShiftRight, 5 Average, 6 MirrorX, 7 MirrorY.
- host_valid  in  1  host command valid.
- host_ready  out  1  scheduler can accept host_cmd.
- lcd_cmd  out  3  command to the controller.
- lcd_cmd_valid  out  1  single-cycle issue strobe.
- lcd_busy  in  1  controller busy (image load / write-back in progress).
- lcd_done  in  1  controller finished write-back.
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- issue_cnt  out  CNT_W  commands issued since reset; saturates at all-ones.
- sched_done  out  1  Write completed; sticky until reset.
- err_timeout  out  1  lcd_done not seen within TIMEOUT; sticky until reset.

Behaviour:
- Reset values: host_ready=1, lcd_cmd=0, lcd_cmd_valid=0, fifo_level=0, issue_cnt=0, sched_done=0, err_timeout=0, sealed=0, state=IDLE, FIFO empty.
- Reset mid-operation clears everything immediately, including FIFO contents and any in-flight strobe. No command survives reset.
- Host handshake:
  - A push occurs on a cycle with host_valid & host_ready.
  - host_ready = !full & !sealed (combinational).
  - Pushing a Write (code 0) sets sealed. host_ready stays 0 until reset; later host commands are never accepted.
- FIFO:
  - Synchronous, first-word-fall-through head.
  - Simultaneous push and pop is legal when not full; fifo_level is unchanged that cycle.
  - Push when full cannot occur because host_ready is 0.
  - Pop only happens in ISSUE.
- States:
  - IDLE: wait for lcd_busy=0 and FIFO non-empty, then go to ISSUE.
  - ISSUE (one cycle): pop the head; register lcd_cmd=head and lcd_cmd_valid=1 for the next cycle. Head=Write goes to WAIT_DONE; otherwise GAP (or IDLE if GAP_CYCLES=0).
  - GAP: count GAP_CYCLES cycles with lcd_cmd_valid=0, then go to IDLE.
  - WAIT_DONE: count cycles. lcd_done=1 goes to FINISH. If the count reaches TIMEOUT, set err_timeout and stay in WAIT_DONE; a later lcd_done still completes.
  - FINISH: sched_done=1. Terminal until reset.
- Latency: an entry pushed into an empty FIFO while lcd_busy=0 in IDLE appears as lcd_cmd_valid 3 cycles after the push edge (push, IDLE decision, ISSUE, strobe).
- Busy sampling:
  - lcd_busy is sampled only in IDLE. A busy rise after the ISSUE decision does not cancel the strobe.
  - lcd_busy=1 holds commands in the FIFO indefinitely, with no loss.
- lcd_cmd_valid is never high on two consecutive cycles. lcd_cmd holds its value when valid is low.
- issue_cnt increments on each strobe cycle.
- lcd_done outside WAIT_DONE is ignored.

Decomposition:
- Package lcd_pkg holds:
  - the command code constants CMD_WRITE .. CMD_MIRROR_Y;
  - the scheduler state encoding IDLE/ISSUE/GAP/WAIT_DONE/FINISH.
- One sub-module: lcd_cmd_fifo, a parameterised synchronous FIFO with push, pop, head, level, full and empty. The FSM, counters and watchdog stay in lcd_cmd_sched.

Test Plan:
1. Hold lcd_busy=1 for 70 cycles; push ShiftUp(1), then Average(5) -> no strobe while busy. After busy falls: strobe with lcd_cmd=1, then strobe with lcd_cmd=5 spaced GAP_CYCLES+2 cycles apart; issue_cnt=2.
2. lcd_busy=1; offer 9 commands back-to-back -> 8 accepted, host_ready=0 after the 8th, fifo_level=8. Drop busy -> 8 strobes in push order, fifo_level returns to 0.
3. Push Write(0), then offer MirrorX(6) -> host_ready=0 from the cycle after the Write push. MirrorX is never accepted; only one strobe with lcd_cmd=0 occurs.
4. After the Write strobe, assert lcd_done 65 cycles later -> sched_done=1 on the next cycle and stays 1; no further strobes.
5. Write strobe with lcd_done withheld -> err_timeout=1 after TIMEOUT=256 cycles. Then assert lcd_done -> sched_done=1; err_timeout stays 1.
6. Three entries queued, state GAP; assert reset for 1 cycle -> lcd_cmd_valid=0, fifo_level=0, issue_cnt=0 immediately. No strobe after release until new pushes arrive.
